// File: rtl/wam_pkg.sv
// rtl/wam_pkg.sv - shared types and constants for the timer display
// Purpose: conversion FSM state encoding, blank and digit segment codes,
//   and the double-dabble nibble correction helper.
// Ports: none (package).
package wam_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  // Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  localparam int BIN_W     = 6;
  localparam int SCRATCH_W = 8 + BIN_W;
  localparam logic [2:0] SHIFT_STEPS = 3'd6;

  // A nibble of 5 or more would overflow past 9 once doubled, so it is
  // pre-corrected by 3 before the shift.
  function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - BCD digit to active-low 7-segment pattern
// Purpose: combinational decode of one BCD digit; codes above 9 blank the digit.
// Ports:
//   bcd  in  4  BCD digit
//   seg  out 7  segments {g..a}, active-low
module seg7_decoder
  import wam_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/timer_display.sv
// rtl/timer_display.sv - seconds-remaining to two-digit 7-segment display
// Purpose: tracks the countdown value, converts it to BCD with a sequential
//   double-dabble engine, drives two active-low digits and pulses game_over
//   when the count falls to zero during a game.
// Optional feature: define BLINK_LAST_TEN_EN to blink both digits during
//   the last ten seconds of a game (half-period BLINK_DIV clk cycles).
// Ports:
//   clk           in   1  system clock
//   reset         in   1  asynchronous, active-high reset
//   start_game    in   1  game running; qualifies game_over and blink
//   seconds_left  in   6  countdown value 0..63
//   hex_tens      out  7  tens digit segments {g..a}, active-low
//   hex_ones      out  7  ones digit segments {g..a}, active-low
//   busy          out  1  conversion in progress
//   game_over     out  1  one-cycle pulse when the count reaches zero in a game
module timer_display
  import wam_pkg::*;
#(
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_game,
  input  logic [5:0] seconds_left,
  output logic [6:0] hex_tens,
  output logic [6:0] hex_ones,
  output logic       busy,
  output logic       game_over
);

  state_t                 state;
  state_t                 state_next;
  logic [BIN_W-1:0]       last_val;
  logic                   pending;
  logic                   changed;
  logic [SCRATCH_W-1:0]   scratch;
  logic [SCRATCH_W-1:0]   adjusted;
  logic [SCRATCH_W-1:0]   shifted;
  logic [2:0]             bit_cnt;
  logic [6:0]             seg_tens;
  logic [6:0]             seg_ones;
  logic [6:0]             hex_tens_q;
  logic [6:0]             hex_ones_q;

  // last_val always holds the previous cycle's sample, so it doubles as the
  // "previous sample" for the game_over edge detect.
  assign changed = (seconds_left != last_val);

  assign adjusted = {dabble_adj(scratch[13:10]), dabble_adj(scratch[9:6]), scratch[5:0]};
  assign shifted  = adjusted << 1;

  seg7_decoder u_dec_tens (.bcd(scratch[13:10]), .seg(seg_tens));
  seg7_decoder u_dec_ones (.bcd(scratch[9:6]),   .seg(seg_ones));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A change seen while idle starts the conversion in the same cycle; LOAD
  // then picks up last_val, which has already captured the new value.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pending || changed) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (bit_cnt == 3'd1) state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_val   <= '0;
      pending    <= 1'b1;
      scratch    <= '0;
      bit_cnt    <= '0;
      hex_tens_q <= SEG_BLANK;
      hex_ones_q <= SEG_BLANK;
      busy       <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      if (changed) last_val <= seconds_left;

      // Leaving IDLE consumes any request; a change arriving mid-conversion
      // is remembered and only the newest value survives in last_val.
      if (state == IDLE)  pending <= 1'b0;
      else if (changed)   pending <= 1'b1;

      busy      <= (state_next != IDLE);
      game_over <= start_game && (seconds_left == '0) && (last_val != '0);

      case (state)
        LOAD: begin
          scratch <= {8'b0, last_val};
          bit_cnt <= SHIFT_STEPS;
        end
        SHIFT: begin
          scratch <= shifted;
          bit_cnt <= bit_cnt - 3'd1;
        end
        UPDATE: begin
          hex_tens_q <= seg_tens;
          hex_ones_q <= seg_ones;
        end
        default: ;
      endcase
    end
  end

`ifdef BLINK_LAST_TEN_EN
  localparam int CNT_W = $clog2(BLINK_DIV + 1);

  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;
  logic             blink_zone;

  assign blink_zone = start_game && (last_val >= 6'd1) && (last_val <= 6'd10);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!blink_zone) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  assign hex_tens = (blink_zone && blink_phase) ? SEG_BLANK : hex_tens_q;
  assign hex_ones = (blink_zone && blink_phase) ? SEG_BLANK : hex_ones_q;
`else
  assign hex_tens = hex_tens_q;
  assign hex_ones = hex_ones_q;
`endif

endmodule

// File: tb/tb_timer_display.sv
// tb/tb_timer_display.sv - self-checking bench for timer_display
module tb_timer_display;

  logic       clk;
  logic       reset;
  logic       start_game;
  logic [5:0] seconds_left;
  logic [6:0] hex_tens;
  logic [6:0] hex_ones;
  logic       busy;
  logic       game_over;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [5:0] val;
    logic [6:0] exp_tens;
    logic [6:0] exp_ones;
  } vec_t;

  vec_t vecs[10];
  logic [6:0] seg_tab[10];

  timer_display #(.BLINK_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_game   (start_game),
    .seconds_left (seconds_left),
    .hex_tens     (hex_tens),
    .hex_ones     (hex_ones),
    .busy         (busy),
    .game_over    (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal digits by plain arithmetic, then segment lookup.
  function automatic logic [13:0] model_segs(input int v);
    return {seg_tab[v / 10], seg_tab[v % 10]};
  endfunction

  // Applies a new value right after an edge and measures edges until the
  // expected pair appears.
  task automatic convert_and_check(input string name, input logic [5:0] v,
                                   input logic [6:0] et, input logic [6:0] eo);
    int lat;
    lat = 0;
    seconds_left = v;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (lat == 0 && {hex_tens, hex_ones} == {et, eo}) lat = i;
    end
    check({name, "_lat"}, lat, 9);
    check({name, "_val"}, {hex_tens, hex_ones}, {et, eo});
    check({name, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int busy_cnt;
    int pulses;
    int first_pulse;
    int lat;
    bit saw44;
    logic [5:0] cur;
    logic [5:0] v;
    logic [13:0] e;

    tests_run    = 0;
    tests_failed = 0;

    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    vecs[0] = '{6'd59, 7'h12, 7'h10};
    vecs[1] = '{6'd45, 7'h19, 7'h12};
    vecs[2] = '{6'd44, 7'h19, 7'h19};
    vecs[3] = '{6'd9,  7'h40, 7'h10};
    vecs[4] = '{6'd10, 7'h79, 7'h40};
    vecs[5] = '{6'd0,  7'h40, 7'h40};
    vecs[6] = '{6'd63, 7'h02, 7'h30};
    vecs[7] = '{6'd1,  7'h40, 7'h79};
    vecs[8] = '{6'd19, 7'h79, 7'h10};
    vecs[9] = '{6'd20, 7'h24, 7'h40};

    // Reset state and first conversion of 60.
    reset = 1'b1;
    start_game = 1'b0;
    seconds_left = 6'd60;
    tick(); tick(); tick();
    check("rst_tens", hex_tens, 7'h7F);
    check("rst_ones", hex_ones, 7'h7F);
    check("rst_busy", busy, 1'b0);
    check("rst_go", game_over, 1'b0);
    reset = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (busy) busy_cnt++;
    end
    check("init_busy_cycles", busy_cnt, 8);
    check("init_tens", hex_tens, 7'h02);
    check("init_ones", hex_ones, 7'h40);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      convert_and_check($sformatf("vec%0d", i), vecs[i].val, vecs[i].exp_tens, vecs[i].exp_ones);
      tick();
    end

    // Change twice during a conversion: 44 shown, then 43 final.
    convert_and_check("pre45", 6'd45, 7'h19, 7'h12);
    seconds_left = 6'd44;
    tick(); tick(); tick();
    seconds_left = 6'd43;
    saw44 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if ({hex_tens, hex_ones} == model_segs(44)) saw44 = 1'b1;
    end
    check("mid_saw44", saw44, 1'b1);
    check("mid_final43", {hex_tens, hex_ones}, model_segs(43));
    check("mid_busy", busy, 1'b0);

    // game_over with start_game=1: one pulse, none while zero is held.
    start_game = 1'b1;
    e = model_segs(1);
    convert_and_check("go_pre1", 6'd1, e[13:7], e[6:0]);
    seconds_left = 6'd0;
    pulses = 0;
    first_pulse = 0;
    for (int i = 1; i <= 110; i++) begin
      tick();
      if (game_over) begin
        pulses++;
        if (first_pulse == 0) first_pulse = i;
      end
    end
    check("go_pulses", pulses, 1);
    check("go_first", first_pulse, 1);

    // Same transition with start_game=0: no pulse.
    start_game = 1'b0;
    convert_and_check("go_pre1b", 6'd1, e[13:7], e[6:0]);
    seconds_left = 6'd0;
    pulses = 0;
    for (int i = 0; i < 110; i++) begin
      tick();
      if (game_over) pulses++;
    end
    check("go_nogame", pulses, 0);

    // Reset in the middle of SHIFT.
    e = model_segs(30);
    seconds_left = 6'd30;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    #1;
    check("mrst_tens", hex_tens, 7'h7F);
    check("mrst_ones", hex_ones, 7'h7F);
    check("mrst_busy", busy, 1'b0);
    tick(); tick();
    reset = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (lat == 0 && {hex_tens, hex_ones} == e) lat = i;
    end
    check("mrst_lat", lat, 9);
    check("mrst_val", {hex_tens, hex_ones}, e);

    // Randomized values against the arithmetic model.
    cur = 6'd30;
    for (int i = 0; i < 30; i++) begin
      v = 6'($urandom_range(0, 63));
      if (v == cur) v = v + 6'd1;
      e = model_segs(int'(v));
      convert_and_check($sformatf("rnd%0d_%0d", i, v), v, e[13:7], e[6:0]);
      cur = v;
    end

`ifdef BLINK_LAST_TEN_EN
    // Inside the last ten seconds: exactly half of any 16-cycle window blank.
    start_game = 1'b1;
    seconds_left = 6'd7;
    for (int i = 0; i < 20; i++) tick();
    busy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if ({hex_tens, hex_ones} == 14'h3FFF) busy_cnt++;
      else check("blink_shown", {hex_tens, hex_ones}, model_segs(7));
    end
    check("blink_blank_cnt", busy_cnt, 8);
    seconds_left = 6'd11;
    for (int i = 0; i < 20; i++) tick();
    busy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if ({hex_tens, hex_ones} != model_segs(11)) busy_cnt++;
    end
    check("blink_steady", busy_cnt, 0);
    start_game = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
